// File: rtl/genesis_bus_pkg.sv
// Shared types for the work-RAM arbiter: sequencer states, owner codes and
// the default RAM word-address width.
package genesis_bus_pkg;

    localparam int RAM16_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M68  = 2'd1,
        OWN_Z80  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

endpackage

// File: rtl/ram16_arb_pick.sv
// Combinational winner selection for the work-RAM arbiter.
// ARB_RR_EN selects round-robin between the CPUs; otherwise M68 beats Z80.
module ram16_arb_pick
    import genesis_bus_pkg::*;
(
    input  logic   m68_req,
    input  logic   z80_req,
    input  logic   dma_req,
    input  logic   burst_cap,
    input  logic   rr_ptr,
    output owner_t winner
);

    logic   cpu_pend;
    owner_t cpu_pick;

    assign cpu_pend = m68_req | z80_req;

`ifdef ARB_RR_EN
    // rr_ptr=0 prefers M68, 1 prefers Z80; only consulted on a tie.
    always_comb begin
        cpu_pick = OWN_NONE;
        if (m68_req && z80_req) begin
            cpu_pick = rr_ptr ? OWN_Z80 : OWN_M68;
        end else if (m68_req) begin
            cpu_pick = OWN_M68;
        end else if (z80_req) begin
            cpu_pick = OWN_Z80;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = rr_ptr;

    always_comb begin
        cpu_pick = OWN_NONE;
        if (m68_req) begin
            cpu_pick = OWN_M68;
        end else if (z80_req) begin
            cpu_pick = OWN_Z80;
        end
    end
`endif

    // DMA yields only once its burst budget is spent and a CPU is waiting.
    always_comb begin
        winner = cpu_pick;
        if (dma_req && !(burst_cap && cpu_pend)) begin
            winner = OWN_DMA;
        end
    end

endmodule

// File: rtl/ram16_arbiter.sv
// Work-RAM arbiter: M68, Z80 and VDP DMA share one registered-read 16-bit RAM
// through a fixed IDLE/ISSUE/WAIT/DONE sequencer. Optional macro: ARB_RR_EN.
module ram16_arbiter
    import genesis_bus_pkg::*;
#(
    parameter int ADDR_W    = RAM16_ADDR_W,
    parameter int DMA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m68_req,
    input  logic              m68_we,
    input  logic [ADDR_W-1:0] m68_addr,
    input  logic [15:0]       m68_wdata,
    input  logic [1:0]        m68_be,
    output logic [15:0]       m68_rdata,
    output logic              m68_ack,
    input  logic              z80_req,
    input  logic              z80_we,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [15:0]       z80_wdata,
    input  logic [1:0]        z80_be,
    output logic [15:0]       z80_rdata,
    output logic              z80_ack,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [15:0]       dma_rdata,
    output logic              dma_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic [1:0]        ram_be,
    input  logic [15:0]       ram_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    // Handshake: a requester raises req with we/addr/wdata/be stable and holds
    // them until its one-cycle ack; req sampled in IDLE is accepted and always
    // completes, and req must be low the cycle after ack to avoid a new grant.

    localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

    arb_state_t state, state_next;
    owner_t     owner_q, winner;
    logic [3:0] burst_cnt;
    logic       burst_cap;
    logic       rr_ptr;

    assign burst_cap = (burst_cnt == BURST_MAX);

    ram16_arb_pick u_pick (
        .m68_req   (m68_req),
        .z80_req   (z80_req),
        .dma_req   (dma_req),
        .burst_cap (burst_cap),
        .rr_ptr    (rr_ptr),
        .winner    (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (winner != OWN_NONE) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        owner = owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            burst_cnt <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
            m68_rdata <= '0;
            z80_rdata <= '0;
            dma_rdata <= '0;
            m68_ack   <= 1'b0;
            z80_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    owner_q <= winner;
                    case (winner)
                        OWN_M68: begin
                            ram_en    <= 1'b1;
                            ram_we    <= m68_we;
                            ram_addr  <= m68_addr;
                            ram_wdata <= m68_wdata;
                            ram_be    <= m68_be;
                        end
                        OWN_Z80: begin
                            ram_en    <= 1'b1;
                            ram_we    <= z80_we;
                            ram_addr  <= z80_addr;
                            ram_wdata <= z80_wdata;
                            ram_be    <= z80_be;
                        end
                        OWN_DMA: begin
                            ram_en    <= 1'b1;
                            ram_we    <= 1'b0;
                            ram_addr  <= dma_addr;
                            ram_wdata <= '0;
                            ram_be    <= 2'b11;
                        end
                        default: begin
                            ram_en    <= 1'b0;
                            ram_we    <= 1'b0;
                            ram_addr  <= '0;
                            ram_wdata <= '0;
                            ram_be    <= '0;
                        end
                    endcase
                    // A DMA win with nothing else is impossible when dma_req is
                    // high, so every non-DMA outcome clears the burst count.
                    if (winner == OWN_DMA) begin
                        if (!burst_cap) burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                ST_ISSUE: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
                ST_WAIT: begin
                    case (owner_q)
                        OWN_M68: begin m68_rdata <= ram_rdata; m68_ack <= 1'b1; end
                        OWN_Z80: begin z80_rdata <= ram_rdata; z80_ack <= 1'b1; end
                        OWN_DMA: begin dma_rdata <= ram_rdata; dma_ack <= 1'b1; end
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    m68_ack   <= 1'b0;
                    z80_ack   <= 1'b0;
                    dma_ack   <= 1'b0;
                    owner_q   <= OWN_NONE;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    ram_be    <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (winner == OWN_M68) rr_ptr <= 1'b1;
            else if (winner == OWN_Z80) rr_ptr <= 1'b0;
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

endmodule

// File: doc/ram16_arbiter.md
# ram16_arbiter

Shares the single-port 16-bit work RAM (ADDR_W-bit word address, registered read data) between three requesters: the 68000 bus controller, the Z80 bank-window adapter and the VDP DMA source fetch. It sits between those masters and the RAM block instance. It runs one transaction at a time through a fixed four-state sequencer and returns read data with a one-cycle ack pulse. VDP DMA has priority but is burst-capped so the CPUs are not starved.

## Interface
- ADDR_W, 12, RAM word-address width
- DMA_BURST, 4, max consecutive DMA grants while a CPU request is pending (1..15)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m68_req, m68_we  in  1  68K request / write (1) or read (0)
- m68_addr  in  ADDR_W  68K word address
- m68_wdata  in  16  68K write data
- m68_be  in  2  byte enables, [1]=upper (UDS), [0]=lower (LDS)
- m68_rdata  out  16  68K read data, valid with m68_ack
- m68_ack  out  1  one-cycle completion pulse
- z80_req, z80_we, z80_addr, z80_wdata, z80_be, z80_rdata, z80_ack: same as m68_*, for the Z80 adapter
- dma_req  in  1  VDP DMA read request (read-only master)
- dma_addr  in  ADDR_W  DMA word address
- dma_rdata  out  16  DMA read data, valid with dma_ack
- dma_ack  out  1  one-cycle completion pulse
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W, ram_wdata out 16, ram_be out 2: RAM address, data, byte enables
- ram_rdata  in  16  RAM read data, valid the cycle after the RAM samples en
- owner  out  2  current owner: 0 none, 1 M68, 2 Z80, 3 DMA
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE. ISSUE -> WAIT -> DONE -> IDLE are unconditional.
- IDLE: if any request is high, pick a winner, then register the RAM signals: ram_en=1, ram_we=winner we (DMA: 0), ram_addr, ram_wdata, ram_be (DMA: 2'b11). Set owner and go to ISSUE. With no request, stay in IDLE with all RAM outputs at 0.
- ISSUE: the RAM samples the command at the end of this cycle. ram_en<=0, ram_we<=0. Go to WAIT.
- WAIT: capture ram_rdata into the owner's rdata register (also on writes; the value is don't-care). Set the owner's ack<=1. Go to DONE.
- DONE: ack is high for exactly this cycle. Clear ack. owner<=0. Go to IDLE.
- Winner selection:
  - DMA wins when dma_req=1, unless the burst counter equals DMA_BURST and a CPU request is pending. In that case the CPU winner is chosen instead.
  - Burst counter: 4 bits. Increments on each DMA grant, saturating at DMA_BURST. Clears on any CPU grant, and when dma_req is low in IDLE.
  - Choice between M68 and Z80 is set by the Configuration macro.
- Accepted transactions always complete. A req drop after acceptance does not abort the transaction. A req dropped before acceptance is ignored.
- Requester rule: hold req, we, addr, wdata and be stable until ack. Req must be low in the cycle after ack, or a new request is taken.
- rdata registers hold their value until that requester's next completion.
- be=2'b00 on a write is forwarded unchanged (the RAM writes nothing) and is still acked.

## Timing
- Request sampled in IDLE at cycle N. RAM signals visible in N+1. ram_rdata valid in N+2. ack and rdata visible in N+3. Earliest next acceptance is N+4.
- Sustained throughput: one transaction per 4 cycles.
- Reset (any time, including mid-transaction): state IDLE. All outputs 0: ram_*, *_ack, *_rdata, owner, busy. Burst counter 0, round-robin pointer set to prefer M68. The pending transaction is lost without an ack.
- Simultaneous requests from all three: DMA first, subject to the burst cap.

## Configuration
- ARB_RR_EN defined: round-robin between M68 and Z80. A 1-bit pointer flips to the other CPU after each CPU grant. When only one CPU requests, it wins regardless of the pointer.
- ARB_RR_EN undefined: fixed priority, M68 over Z80. The pointer logic is absent.

## Structure
- Shared package genesis_bus_pkg holds:
  - typedef enum of the arbiter states
  - typedef enum owner_t {OWN_NONE=0, OWN_M68=1, OWN_Z80=2, OWN_DMA=3}
  - RAM16_ADDR_W = 12 constant
- One combinational sub-module, ram16_arb_pick. Inputs: three reqs, burst-cap flag, rr pointer. Output: owner_t winner. The ARB_RR_EN switch lives there.

## Test plan
- Single M68 write (addr 12'h010, wdata 16'hBEEF, be 2'b11), then a read of the same address -> m68_ack pulses 3 cycles after each acceptance, m68_rdata=16'hBEEF.
- M68 and Z80 requesting continuously with ARB_RR_EN defined -> grants alternate M68, Z80, M68, Z80. Without the macro, M68 takes every grant while its req stays high.
- dma_req and m68_req held high, DMA_BURST=4 -> owner sequence DMA×4, M68, DMA×4, M68. dma_rdata matches preloaded RAM contents.
- Byte write: be=2'b01, wdata 16'h1234 to a word preloaded with 16'hFFFF -> readback 16'hFF34.
- rst_n asserted during WAIT -> all outputs 0 immediately with no ack. After release, a new request completes normally with the round-robin pointer preferring M68.
- Z80 req pulsed high, then dropped after acceptance -> the transaction still completes and z80_ack pulses once. Only one RAM access is issued.
